// File: rtl/fp_normalize_round.sv
// Post-adder normalize and round stage for binary32 add/sub.
// Normalizes one left shift per cycle, rounds to nearest-even, and returns a packed result.
module fp_normalize_round #(
    parameter int MW   = 24,
    parameter int EW   = 8,
    parameter int EMAX = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sign_in,
    input  logic [EW-1:0] exp_in,
    input  logic [MW-1:0] mant_in,
    input  logic          carry_in,
    input  logic [2:0]    grs_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   result,
    output logic          flag_ovf,
    output logic          flag_zero
);

    // Two spare exponent bits so increments past EMAX are visible to the overflow compare.
    localparam int XW = EW + 2;

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, OUT} state_t;

    state_t          r_state, w_state_nx;
    logic [MW-1:0]   r_mant;
    logic            r_g, r_r, r_s, r_carry, r_sign;
    logic [XW-1:0]   r_exp;
    logic [31:0]     r_result;
    logic            r_ovf, r_zero, r_out_valid, r_in_ready;

    logic            w_accept, w_all_zero, w_norm_stop;
    logic            w_round_up, w_ovf;
    logic [MW:0]     w_sum;
    logic [MW-1:0]   w_mant_rnd;
    logic [XW-1:0]   w_exp_rnd;
    logic [EW-1:0]   w_exp_fld;

    assign w_accept    = in_valid && r_in_ready;
    assign w_all_zero  = (r_mant == '0) && !r_g && !r_r && !r_s;
    assign w_norm_stop = r_mant[MW-1] || (r_exp == XW'(1));

    assign w_round_up  = r_g & (r_r | r_s | r_mant[0]);
    assign w_sum       = {1'b0, r_mant} + {{MW{1'b0}}, w_round_up};
    assign w_mant_rnd  = w_sum[MW] ? {1'b1, {(MW-1){1'b0}}} : w_sum[MW-1:0];
    assign w_exp_rnd   = r_exp + {{(XW-1){1'b0}}, w_sum[MW]};
    assign w_ovf       = w_exp_rnd >= XW'(EMAX);
    // A denormal that rounds up into the hidden bit picks up exp field 1 from the floor.
    assign w_exp_fld   = w_mant_rnd[MW-1] ? w_exp_rnd[EW-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_state_nx = SHIFT;
            SHIFT: begin
                if (r_carry)          w_state_nx = ROUND;
                else if (w_all_zero)  w_state_nx = OUT;
                else if (w_norm_stop) w_state_nx = ROUND;
                else                  w_state_nx = SHIFT;
            end
            ROUND: w_state_nx = OUT;
            OUT:   if (out_ready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mant      <= '0;
            r_g         <= 1'b0;
            r_r         <= 1'b0;
            r_s         <= 1'b0;
            r_carry     <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= (w_state_nx == OUT);
            r_in_ready  <= (w_state_nx == IDLE);
            case (r_state)
                IDLE: if (w_accept) begin
                    r_mant  <= mant_in;
                    r_g     <= grs_in[2];
                    r_r     <= grs_in[1];
                    r_s     <= grs_in[0];
                    r_carry <= carry_in;
                    r_sign  <= sign_in;
                    r_exp   <= {2'b00, exp_in};
                end
                SHIFT: begin
                    if (r_carry) begin
                        r_mant  <= {1'b1, r_mant[MW-1:1]};
                        r_g     <= r_mant[0];
                        r_r     <= r_g;
                        r_s     <= r_r | r_s;
                        r_exp   <= r_exp + XW'(1);
                        r_carry <= 1'b0;
                    end else if (w_all_zero) begin
                        r_result <= '0;
                        r_zero   <= 1'b1;
                    end else if (!w_norm_stop) begin
                        r_mant <= {r_mant[MW-2:0], r_g};
                        r_g    <= r_r;
                        r_r    <= 1'b0;
                        r_exp  <= r_exp - XW'(1);
                    end
                end
                ROUND: begin
                    r_mant <= w_mant_rnd;
                    r_exp  <= w_exp_rnd;
                    if (w_ovf) begin
                        r_result <= {r_sign, {EW{1'b1}}, {(MW-1){1'b0}}};
                        r_ovf    <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_exp_fld, w_mant_rnd[MW-2:0]};
                    end
                end
                OUT: if (out_ready) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flag_ovf  = r_ovf;
    assign flag_zero = r_zero;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round: hand-computed binary32 results, flags and latencies.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sign_in, carry_in, out_valid, out_ready;
    logic [7:0]  exp_in;
    logic [23:0] mant_in;
    logic [2:0]  grs_in;
    logic [31:0] result;
    logic        flag_ovf, flag_zero;

    int total = 0;
    int bad   = 0;

    fp_normalize_round dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .carry_in(carry_in),
        .grs_in(grs_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_ovf(flag_ovf), .flag_zero(flag_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one operand set and count rising edges after the accepting edge until out_valid.
    task automatic launch(input logic s, input logic [7:0] e, input logic [23:0] m,
                          input logic c, input logic [2:0] grs, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        sign_in = s; exp_in = e; mant_in = m; carry_in = c; grs_in = grs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic vec(input string tag, input logic s, input logic [7:0] e,
                       input logic [23:0] m, input logic c, input logic [2:0] grs,
                       input logic [31:0] exp_res, input logic exp_ovf, input logic exp_zero,
                       input int exp_lat);
        int lat;
        launch(s, e, m, c, grs, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, result, exp_res);
        check({tag, "_flags"}, {30'd0, flag_ovf, flag_zero}, {30'd0, exp_ovf, exp_zero});
        @(posedge clk);
        #1;
    endtask

    int          lat;
    logic [31:0] held;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sign_in = 1'b0; exp_in = 8'd0; mant_in = 24'd0; carry_in = 1'b0; grs_in = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", {30'd0, flag_ovf, flag_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Latencies count edges after the accepting edge: T+3+k -> 2+k, zero -> 1.
        vec("one_plus_one",  1'b0, 8'd127, 24'h000000, 1'b1, 3'b000, 32'h40000000, 1'b0, 1'b0, 2);
        vec("neg_two",       1'b1, 8'd127, 24'h000000, 1'b1, 3'b000, 32'hC0000000, 1'b0, 1'b0, 2);
        vec("onehalf_m_one", 1'b0, 8'd127, 24'h400000, 1'b0, 3'b000, 32'h3F000000, 1'b0, 1'b0, 3);
        vec("tie_carry",     1'b0, 8'd127, 24'hFFFFFF, 1'b0, 3'b100, 32'h40000000, 1'b0, 1'b0, 2);
        vec("tie_even",      1'b0, 8'd127, 24'h800002, 1'b0, 3'b100, 32'h3F800002, 1'b0, 1'b0, 2);
        vec("tie_odd",       1'b0, 8'd127, 24'h800001, 1'b0, 3'b100, 32'h3F800002, 1'b0, 1'b0, 2);
        vec("sticky_up",     1'b0, 8'd127, 24'h800000, 1'b0, 3'b101, 32'h3F800001, 1'b0, 1'b0, 2);
        vec("cancel",        1'b1, 8'd127, 24'h000000, 1'b0, 3'b000, 32'h00000000, 1'b0, 1'b1, 1);
        vec("overflow",      1'b0, 8'd254, 24'h000000, 1'b1, 3'b000, 32'h7F800000, 1'b1, 1'b0, 2);
        vec("denorm_floor",  1'b0, 8'd1,   24'h400000, 1'b0, 3'b000, 32'h00400000, 1'b0, 1'b0, 2);
        vec("denorm_to_norm",1'b0, 8'd1,   24'h7FFFFF, 1'b0, 3'b110, 32'h00800000, 1'b0, 1'b0, 2);
        vec("guard_shift_in",1'b0, 8'd127, 24'h400000, 1'b0, 3'b100, 32'h3F000001, 1'b0, 1'b0, 3);
        vec("guard_only",    1'b0, 8'd127, 24'h000000, 1'b0, 3'b100, 32'h33800000, 1'b0, 1'b0, 26);

        // Backpressure: output held, extra inputs ignored.
        out_ready = 1'b0;
        launch(1'b0, 8'd254, 24'h000000, 1'b1, 3'b000, lat);
        check("bp_lat", 32'(lat), 32'd2);
        held = result;
        check("bp_res", held, 32'h7F800000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; mant_in = 24'h123456; exp_in = 8'd9; carry_in = 1'b0;
            @(posedge clk);
            #1;
            check("bp_hold_res", result, held);
            check("bp_hold_vld_rdy_ovf", {29'd0, out_valid, in_ready, flag_ovf}, 32'b101);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {29'd0, out_valid, in_ready, flag_ovf}, 32'b010);
        vec("after_bp",      1'b0, 8'd127, 24'h800002, 1'b0, 3'b100, 32'h3F800002, 1'b0, 1'b0, 2);

        // Asynchronous reset while shifting.
        @(negedge clk);
        sign_in = 1'b0; exp_in = 8'd127; mant_in = 24'h000000; carry_in = 1'b0; grs_in = 3'b100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_vld_rdy", {30'd0, out_valid, in_ready}, 32'b01);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_flags", {30'd0, flag_ovf, flag_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vec("after_rst",     1'b0, 8'd127, 24'h000000, 1'b1, 3'b000, 32'h40000000, 1'b0, 1'b0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
